// File: rtl/pulse_scheduler.sv
// Round-robin pulse scheduler: grants one of four request sources at a time and
// emits a stretched pulse with a guaranteed low gap. Optional macro PULSE_SCHED_OVF_EN
// enables the sticky per-source overflow flags.
module pulse_scheduler #(
    parameter int unsigned STRETCH_LEN = 4,
    parameter int unsigned GAP_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_in,
    input  logic       ovf_clr,
    output logic       pulse_out,
    output logic [1:0] id_out,
    output logic       busy,
    output logic [3:0] overflow
);

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   pulse_q, pulse_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_SRC-1:0]     pending_q, pending_d;
    logic [ID_W-1:0]        last_q, last_d;

    logic [NUM_SRC-1:0]     cand;
    logic                   gnt_vld;
    logic [ID_W-1:0]        gnt_idx;
    logic [ID_W-1:0]        srch_idx;
    logic [NUM_SRC-1:0]     grant_oh;
    logic [NUM_SRC-1:0]     ovf_evt;

    assign cand = pending_q | req_in;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        srch_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            srch_idx = last_q + ID_W'(k + 1);
            if (!gnt_vld && cand[srch_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = srch_idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_oh = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d           = PULSE;
                    pulse_d           = 1'b1;
                    id_d              = gnt_idx;
                    last_d            = gnt_idx;
                    cnt_d             = CNT_W'(STRETCH_LEN - 1);
                    grant_oh[gnt_idx] = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    pulse_d = 1'b0;
                    cnt_d   = CNT_W'(GAP_LEN - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // A granted source keeps its pending bit only if a fresh request arrives with it.
    assign pending_d = (grant_oh & pending_q & req_in) | (~grant_oh & (pending_q | req_in));
    assign ovf_evt   = req_in & pending_q & ~grant_oh;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pulse_q   <= 1'b0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pending_q <= '0;
            last_q    <= ID_W'(NUM_SRC - 1);
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            last_q    <= last_d;
        end
    end

`ifdef PULSE_SCHED_OVF_EN
    logic [NUM_SRC-1:0] ovf_q;

    // Sticky flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_clr ? '0 : ovf_q) | ovf_evt;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^{ovf_clr, ovf_evt};
    assign overflow   = '0;
`endif

    assign pulse_out = pulse_q;
    assign id_out    = id_q;
    assign busy      = busy_q;

endmodule
